ram_dp_be: RTL and testbench

Parametrised simple-dual-port synchronous RAM with per-byte write enables, a registered read port with valid flag, and write-to-read bypass. It also contains a hardware clear engine that zero-fills the whole array after reset or on request. It succeeds the single-port RAM as the general storage primitive for sample buffers and lookup tables in the temperature datapath.

---
 rtl/ram_dp_be.sv | 90 +++++++++
 tb/tb_ram_dp_be.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port RAM with byte enables, registered read, write-first bypass and zero-fill clear engine
//   clk, rst        : clock, asynchronous active-high reset (restarts the zero-fill sweep)
//   clr / busy      : request a zero-fill while idle / clear engine owns the array
//   wr_en, wr_addr, wr_data, wr_be : write port, wr_be[i] gates byte lane i
//   rd_en, rd_addr  : read request
//   rd_data, rd_valid : registered read data and its one-cycle strobe
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH = 4096,
  localparam int BYTES = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [BYTES-1:0]         wr_be,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, rd_merge;
  logic rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic mem_we;
  logic [IW-1:0] mem_idx;
  logic [BYTES-1:0] mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic wr_ok, rd_ok, byp;
  assign wr_ok = {1'b0, wr_addr} < (ADDRESS_WIDTH+1)'(DEPTH);
  assign rd_ok = {1'b0, rd_addr} < (ADDRESS_WIDTH+1)'(DEPTH);
  // bypass only matters when the write actually lands this cycle
  assign byp = wr_en && wr_ok && wr_addr == rd_addr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  always_comb begin
    rd_merge = mem[rd_addr[IW-1:0]];
    for (int i = 0; i < BYTES; i++)
      if (byp && wr_be[i]) rd_merge[8*i +: 8] = wr_data[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == ADDRESS_WIDTH'(DEPTH - 1) ? IDLE : CLEAR;
    end else if (clr) begin
      state_d = CLEAR;
      cnt_d = '0;
    end else if (rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d = rd_ok ? rd_merge : '0;
    end
  end
  // the clear sweep and user writes share the single write port
  always_comb begin
    busy = state_q == CLEAR;
    mem_we = busy || (!clr && wr_en && wr_ok);
    mem_idx = busy ? cnt_q[IW-1:0] : wr_addr[IW-1:0];
    mem_be = busy ? '1 : wr_be;
    mem_wdata = busy ? '0 : wr_data;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++)
      if (mem_we && mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: checks a 16-word and a 12-word instance driven in parallel against a word-level model
module tb_ram_dp_be;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0] wr_be = '0;
  logic rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic busy_o [2];
  logic [31:0] rd_data_o [2];
  logic rd_valid_o [2];
  logic [31:0] mm [2][16];
  int left [2];
  logic [31:0] ed [2];
  logic ev [2];
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  ram_dp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .DEPTH(16)) u16 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]));
  ram_dp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .DEPTH(12)) u12 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset(input int k);
    left[k] = k == 0 ? 16 : 12;
    ev[k] = 1'b0;
    for (int a = 0; a < 16; a++) mm[k][a] = '0;
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(left[k] > 0));
      chk($sformatf("rd_valid%0d", k), 32'(rd_valid_o[k]), 32'(ev[k]));
      chk($sformatf("rd_data%0d", k), rd_data_o[k], ed[k]);
    end
  endtask
  task automatic cyc();
    int dep;
    logic [31:0] mask;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      dep = k == 0 ? 16 : 12;
      if (rst) begin
        model_reset(k);
        ed[k] = '0;
      end else if (left[k] > 0) begin
        left[k]--;
        ev[k] = 1'b0;
      end else if (clr) begin
        model_reset(k);
      end else begin
        if (wr_en && int'(wr_addr) < dep) begin
          mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
          mm[k][wr_addr] = (mm[k][wr_addr] & ~mask) | (wr_data & mask);
        end
        ev[k] = rd_en;
        if (rd_en) ed[k] = int'(rd_addr) < dep ? mm[k][rd_addr] : '0;
      end
    end
    #1;
    check_all();
  endtask
  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask
  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      ed[k] = '0;
    end
    check_all();
    chk("rst_busy_lit", 32'(busy_o[0]), 32'd1);
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) ed[k] = '0;
    async_reset();
    for (int i = 0; i < 17; i++) cyc();
    chk("sweep_done_lit", 32'(busy_o[0]), 32'd0);
    for (int a = 0; a < 16; a++) begin
      idle(); rd(4'(a)); cyc();
      chk("zero_read_lit", rd_data_o[0], 32'd0);
    end
    idle(); wr(4'd5, 32'hDEADBEEF, 4'b1111); cyc();
    idle(); rd(4'd5); cyc();
    chk("full_wr_lit", rd_data_o[0], 32'hDEADBEEF);
    idle(); cyc();
    chk("valid_drop_lit", 32'(rd_valid_o[0]), 32'd0);
    wr(4'd5, 32'h0000AA00, 4'b0010); cyc();
    idle(); rd(4'd5); cyc();
    chk("partial_lit", rd_data_o[0], 32'hDEADAAEF);
    idle(); wr(4'd5, 32'h12345678, 4'b0000); cyc();
    idle(); rd(4'd5); cyc();
    chk("be0_lit", rd_data_o[0], 32'hDEADAAEF);
    idle(); wr(4'd7, 32'h11223344, 4'b1111); cyc();
    idle(); wr(4'd7, 32'hAABBCCDD, 4'b1100); rd(4'd7); cyc();
    chk("bypass_lit", rd_data_o[0], 32'hAABB3344);
    for (int i = 0; i < 400; i++) begin
      clr = $urandom_range(63) == 0;
      wr_en = $urandom_range(1);
      wr_addr = 4'($urandom);
      wr_data = $urandom;
      wr_be = 4'($urandom);
      rd_en = $urandom_range(1);
      rd_addr = $urandom_range(3) == 0 ? wr_addr : 4'($urandom);
      cyc();
    end
    idle();
    for (int i = 0; i < 20; i++) cyc();
    for (int a = 0; a < 4; a++) begin
      wr(4'(a * 3), 32'hC0DE0000 | 32'(a), 4'b1111); cyc();
    end
    idle(); clr = 1'b1; rd(4'd3); cyc();
    chk("clr_novalid_lit", 32'(rd_valid_o[0]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      clr = $urandom_range(1);
      wr(4'($urandom), $urandom, 4'b1111);
      rd(4'($urandom));
      cyc();
    end
    idle();
    for (int a = 0; a < 16; a++) begin
      rd(4'(a)); cyc();
      chk("post_clr_lit", rd_data_o[0], 32'd0);
    end
    idle(); wr(4'd2, 32'h55AA55AA, 4'b1111); cyc();
    idle(); clr = 1'b1; cyc();
    idle();
    for (int i = 0; i < 6; i++) cyc();
    async_reset();
    for (int i = 0; i < 17; i++) cyc();
    wr(4'd13, 32'hFEEDFACE, 4'b1111); cyc();
    idle(); rd(4'd13); cyc();
    chk("oor_read_lit", rd_data_o[1], 32'd0);
    chk("oor_valid_lit", 32'(rd_valid_o[1]), 32'd1);
    chk("inrange16_lit", rd_data_o[0], 32'hFEEDFACE);
    idle(); rd(4'd1); cyc();
    idle(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
